// File: rtl/raster_line_setup.sv
// raster_line_setup
// Producer side of the rasterizer's per-frame / per-line coefficient interface.
// The vertex stage fills a shadow bank through a serial write port and commits
// it. At the frame boundary the committed shadow bank becomes the active bank.
// On every stepped line the ten line-start accumulators (six edge functions and
// four barycentrics) advance by their per-line deltas during hblank, one
// accumulator per cycle through a single shared adder.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   x, y                       VGA column / line counters
//   cfg_wr, cfg_addr, cfg_data shadow bank write port (edge / y words use [19:0])
//   cfg_commit                 marks the shadow bank complete
//   cfg_ready                  high while writes / commit are accepted
//   frame_swap                 one-cycle pulse when the shadow bank becomes active
//   y_screen_v0..v3            active-bank vertex screen y
//   e*_init_t*                 edge line-start values (20-bit two's complement)
//   bar_iy .. bar2_iz          barycentric line-start values (Q2.20)
//   bar_*_dx                   active-bank per-pixel deltas
//
// Optional build macro RASTER_SETUP_OVERRUN_EN adds cfg_overrun (sticky flag)
// and overrun_cnt (saturating count of strobes dropped while cfg_ready is low).
module raster_line_setup #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        cfg_wr,
  input  logic [4:0]  cfg_addr,
  input  logic [21:0] cfg_data,
  input  logic        cfg_commit,
  output logic        cfg_ready,
  output logic        frame_swap,
  output logic [19:0] y_screen_v0,
  output logic [19:0] y_screen_v1,
  output logic [19:0] y_screen_v2,
  output logic [19:0] y_screen_v3,
  output logic [19:0] e0_init_t1,
  output logic [19:0] e1_init_t1,
  output logic [19:0] e2_init_t1,
  output logic [19:0] e0_init_t2,
  output logic [19:0] e1_init_t2,
  output logic [19:0] e2_init_t2,
  output logic [21:0] bar_iy,
  output logic [21:0] bar_iz,
  output logic [21:0] bar2_iy,
  output logic [21:0] bar2_iz,
  output logic [21:0] bar_iy_dx,
  output logic [21:0] bar_iz_dx,
  output logic [21:0] bar2_iy_dx,
  output logic [21:0] bar2_iz_dx
`ifdef RASTER_SETUP_OVERRUN_EN
  , output logic        cfg_overrun
  , output logic [7:0]  overrun_cnt
`endif
);

  localparam logic [9:0] TRIG_X     = 10'(H_ACTIVE);
  localparam logic [9:0] STEP_Y_LIM = 10'(V_ACTIVE - 1);
  localparam logic [9:0] SWAP_Y     = 10'(V_TOTAL - 1);
  localparam logic [4:0] NUM_WORDS  = 5'd28;
  localparam logic [3:0] LAST_ACC   = 4'd9;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_STEP = 1'b1;

  logic [21:0] shadow_q [0:27];
  logic [21:0] shadow_d [0:27];
  logic [21:0] active_q [0:27];
  logic [21:0] active_d [0:27];
  logic [21:0] acc_q    [0:9];
  logic [21:0] acc_d    [0:9];
  logic        pending_q,    pending_d;
  logic        frame_swap_q, frame_swap_d;
  logic        load_q,       load_d;
  logic [0:0]  state_q,      state_d;
  logic [3:0]  cnt_q,        cnt_d;

  logic        swap_hit;
  logic        step_hit;
  logic [21:0] add_sum;

  // Accumulators 0-5 are edges (bases at 0-5), 6-9 are barycentrics (bases at 12-15).
  function automatic logic [4:0] base_addr(input logic [3:0] idx);
    if (idx < 4'd6) return {1'b0, idx};
    else            return {1'b0, idx} + 5'd6;
  endfunction

  // Edge per-line deltas sit at 6-11, barycentric per-line deltas at 16-19.
  function automatic logic [4:0] delta_addr(input logic [3:0] idx);
    if (idx < 4'd6) return {1'b0, idx} + 5'd6;
    else            return {1'b0, idx} + 5'd10;
  endfunction

  assign swap_hit = (y == SWAP_Y) && (x == TRIG_X);
  assign step_hit = (y < STEP_Y_LIM) && (x == TRIG_X);

  // The single shared adder; edges keep only their low 20 bits, so the
  // full-width sum wraps correctly for both word sizes.
  assign add_sum = acc_q[cnt_q] + active_q[delta_addr(cnt_q)];

  // Next-state logic for banks, handshake, base reload and the step sequencer.
  always_comb begin
    shadow_d     = shadow_q;
    active_d     = active_q;
    acc_d        = acc_q;
    pending_d    = pending_q;
    frame_swap_d = 1'b0;
    load_d       = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;

    // A write in the same cycle as the commit lands first and joins the commit.
    if (!pending_q && cfg_wr && (cfg_addr < NUM_WORDS)) begin
      shadow_d[cfg_addr] = cfg_data;
    end else begin
      shadow_d = shadow_q;
    end

    if (!pending_q && cfg_commit) begin
      pending_d = 1'b1;
    end else if (pending_q && swap_hit) begin
      active_d     = shadow_q;
      pending_d    = 1'b0;
      frame_swap_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    // Reload happens at every frame boundary so an uncommitted frame repeats.
    if (swap_hit) begin
      load_d = 1'b1;
    end else begin
      load_d = 1'b0;
    end

    if (load_q) begin
      for (int i = 0; i < 10; i++) begin
        acc_d[i] = active_q[base_addr(4'(i))];
      end
    end else begin
      acc_d = acc_q;
    end

    case (state_q)
      S_IDLE: begin
        if (step_hit) begin
          state_d = S_STEP;
          cnt_d   = 4'd0;
        end else begin
          state_d = S_IDLE;
          cnt_d   = cnt_q;
        end
      end
      S_STEP: begin
        acc_d[cnt_q] = add_sum;
        if (cnt_q == LAST_ACC) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          state_d = S_STEP;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 28; i++) begin
        shadow_q[i] <= 22'd0;
        active_q[i] <= 22'd0;
      end
      for (int i = 0; i < 10; i++) begin
        acc_q[i] <= 22'd0;
      end
      pending_q    <= 1'b0;
      frame_swap_q <= 1'b0;
      load_q       <= 1'b0;
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      acc_q        <= acc_d;
      pending_q    <= pending_d;
      frame_swap_q <= frame_swap_d;
      load_q       <= load_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
    end
  end

  assign cfg_ready   = !pending_q;
  assign frame_swap  = frame_swap_q;
  assign e0_init_t1  = acc_q[0][19:0];
  assign e1_init_t1  = acc_q[1][19:0];
  assign e2_init_t1  = acc_q[2][19:0];
  assign e0_init_t2  = acc_q[3][19:0];
  assign e1_init_t2  = acc_q[4][19:0];
  assign e2_init_t2  = acc_q[5][19:0];
  assign bar_iy      = acc_q[6];
  assign bar_iz      = acc_q[7];
  assign bar2_iy     = acc_q[8];
  assign bar2_iz     = acc_q[9];
  assign bar_iy_dx   = active_q[20];
  assign bar_iz_dx   = active_q[21];
  assign bar2_iy_dx  = active_q[22];
  assign bar2_iz_dx  = active_q[23];
  assign y_screen_v0 = active_q[24][19:0];
  assign y_screen_v1 = active_q[25][19:0];
  assign y_screen_v2 = active_q[26][19:0];
  assign y_screen_v3 = active_q[27][19:0];

`ifdef RASTER_SETUP_OVERRUN_EN
  logic       overrun_q, overrun_d;
  logic [7:0] ovr_cnt_q, ovr_cnt_d;
  logic [1:0] drop_n;
  logic [8:0] ovr_sum;

  // Write and commit strobes are counted separately when both are dropped.
  always_comb begin
    drop_n  = {1'b0, cfg_wr & pending_q} + {1'b0, cfg_commit & pending_q};
    ovr_sum = {1'b0, ovr_cnt_q} + {7'd0, drop_n};
    if (ovr_sum > 9'd255) begin
      ovr_cnt_d = 8'd255;
    end else begin
      ovr_cnt_d = ovr_sum[7:0];
    end
    if (drop_n != 2'd0) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Overrun status registers, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
      ovr_cnt_q <= 8'd0;
    end else begin
      overrun_q <= overrun_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign cfg_overrun = overrun_q;
  assign overrun_cnt = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_raster_line_setup.sv
module tb_raster_line_setup;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  x, y;
  logic        cfg_wr, cfg_commit;
  logic [4:0]  cfg_addr;
  logic [21:0] cfg_data;
  logic        cfg_ready, frame_swap;
  logic [19:0] y_screen_v0, y_screen_v1, y_screen_v2, y_screen_v3;
  logic [19:0] e0_init_t1, e1_init_t1, e2_init_t1, e0_init_t2, e1_init_t2, e2_init_t2;
  logic [21:0] bar_iy, bar_iz, bar2_iy, bar2_iz;
  logic [21:0] bar_iy_dx, bar_iz_dx, bar2_iy_dx, bar2_iz_dx;
`ifdef RASTER_SETUP_OVERRUN_EN
  logic        cfg_overrun;
  logic [7:0]  overrun_cnt;
`endif

  raster_line_setup dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .cfg_ready(cfg_ready), .frame_swap(frame_swap),
    .y_screen_v0(y_screen_v0), .y_screen_v1(y_screen_v1),
    .y_screen_v2(y_screen_v2), .y_screen_v3(y_screen_v3),
    .e0_init_t1(e0_init_t1), .e1_init_t1(e1_init_t1), .e2_init_t1(e2_init_t1),
    .e0_init_t2(e0_init_t2), .e1_init_t2(e1_init_t2), .e2_init_t2(e2_init_t2),
    .bar_iy(bar_iy), .bar_iz(bar_iz), .bar2_iy(bar2_iy), .bar2_iz(bar2_iz),
    .bar_iy_dx(bar_iy_dx), .bar_iz_dx(bar_iz_dx),
    .bar2_iy_dx(bar2_iy_dx), .bar2_iz_dx(bar2_iz_dx)
`ifdef RASTER_SETUP_OVERRUN_EN
    , .cfg_overrun(cfg_overrun), .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: shadow/active banks as plain arrays; line-start values are
  // computed in closed form as base + steps*delta, wrapped to the word width.
  logic [21:0] m_shadow [0:27];
  logic [21:0] m_active [0:27];
  bit          m_pending;
  int          m_steps;
  int          m_drops;

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed 0x%0h expected 0x%0h", tag, idx, obs, exp);
    end
  endtask

  function automatic logic [21:0] exp_acc(input int i, input int n);
    longint b, d, v;
    logic [63:0] vb;
    if (i < 6) begin b = longint'(m_active[i]);     d = longint'(m_active[i + 6]);  end
    else       begin b = longint'(m_active[i + 6]); d = longint'(m_active[i + 10]); end
    v  = b + longint'(n) * d;
    vb = v;
    if (i < 6) return {2'b00, vb[19:0]};
    else       return vb[21:0];
  endfunction

  function automatic logic [21:0] dut_acc(input int i);
    case (i)
      0: return {2'b00, e0_init_t1};
      1: return {2'b00, e1_init_t1};
      2: return {2'b00, e2_init_t1};
      3: return {2'b00, e0_init_t2};
      4: return {2'b00, e1_init_t2};
      5: return {2'b00, e2_init_t2};
      6: return bar_iy;
      7: return bar_iz;
      8: return bar2_iy;
      default: return bar2_iz;
    endcase
  endfunction

  function automatic logic [21:0] dut_aux(input int i);
    case (i)
      0: return bar_iy_dx;
      1: return bar_iz_dx;
      2: return bar2_iy_dx;
      3: return bar2_iz_dx;
      4: return {2'b00, y_screen_v0};
      5: return {2'b00, y_screen_v1};
      6: return {2'b00, y_screen_v2};
      default: return {2'b00, y_screen_v3};
    endcase
  endfunction

  task automatic check_all(input string tag);
    logic [21:0] w;
    for (int i = 0; i < 10; i++) chk({tag, ".acc"}, i, 32'(dut_acc(i)), 32'(exp_acc(i, m_steps)));
    for (int i = 0; i < 4; i++)  chk({tag, ".dx"}, i, 32'(dut_aux(i)), 32'(m_active[20 + i]));
    for (int i = 0; i < 4; i++) begin
      w = m_active[24 + i];
      chk({tag, ".ysc"}, i, 32'(dut_aux(4 + i)), {12'd0, w[19:0]});
    end
  endtask

  task automatic chk_ovr(input string tag);
`ifdef RASTER_SETUP_OVERRUN_EN
    chk({tag, ".overrun"}, 0, 32'(cfg_overrun), (m_drops > 0) ? 32'd1 : 32'd0);
    chk({tag, ".ovr_cnt"}, 0, 32'(overrun_cnt), (m_drops > 255) ? 32'd255 : 32'(m_drops));
`else
    chk({tag, ".ready"}, 0, 32'(cfg_ready), m_pending ? 32'd0 : 32'd1);
`endif
  endtask

  task automatic tick(input logic [9:0] xv, input logic [9:0] yv);
    x = xv; y = yv;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [21:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
    if (m_pending) m_drops++;
    else if (a < 5'd28) m_shadow[a] = d;
    tick(10'd0, 10'd500);
    cfg_wr = 1'b0;
  endtask

  task automatic cfg_commit_pulse();
    cfg_commit = 1'b1;
    if (m_pending) m_drops++;
    else m_pending = 1'b1;
    tick(10'd0, 10'd500);
    cfg_commit = 1'b0;
  endtask

  task automatic write_and_commit(input logic [4:0] a, input logic [21:0] d);
    cfg_wr = 1'b1; cfg_commit = 1'b1; cfg_addr = a; cfg_data = d;
    if (m_pending) m_drops += 2;
    else begin
      if (a < 5'd28) m_shadow[a] = d;
      m_pending = 1'b1;
    end
    tick(10'd0, 10'd500);
    cfg_wr = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic do_swap(input string tag);
    logic exp_fs;
    exp_fs = m_pending;
    if (m_pending) begin
      for (int i = 0; i < 28; i++) m_active[i] = m_shadow[i];
      m_pending = 1'b0;
    end
    tick(10'd640, 10'd524);
    chk({tag, ".frame_swap"}, 1, 32'(frame_swap), 32'(exp_fs));
    chk({tag, ".cfg_ready"}, 0, 32'(cfg_ready), 32'd1);
    tick(10'd641, 10'd524);
    chk({tag, ".frame_swap"}, 2, 32'(frame_swap), 32'd0);
    m_steps = 0;
    check_all({tag, ".load"});
  endtask

  task automatic do_line(input string tag, input int line);
    tick(10'd640, 10'(line));
    for (int k = 641; k <= 650; k++) tick(10'(k), 10'(line));
    tick(10'd799, 10'(line));
    if (line < 479) m_steps++;
    check_all(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  vec, want;
    logic [4:0]  ra;

    for (int i = 0; i < 28; i++) begin m_shadow[i] = 22'd0; m_active[i] = 22'd0; end
    m_pending = 1'b0; m_steps = 0; m_drops = 0;
    rst_n = 1'b0; x = 10'd0; y = 10'd500;
    cfg_wr = 1'b0; cfg_commit = 1'b0; cfg_addr = 5'd0; cfg_data = 22'd0;

    // Reset state
    tick(10'd0, 10'd500);
    tick(10'd0, 10'd500);
    chk("rst.cfg_ready", 0, 32'(cfg_ready), 32'd1);
    chk("rst.frame_swap", 0, 32'(frame_swap), 32'd0);
    check_all("rst");
    chk_ovr("rst");
    rst_n = 1'b1;
    tick(10'd0, 10'd500);

    // Basic write, commit and frame swap
    cfg_write(5'd0, 22'd100);
    cfg_write(5'd6, 22'h3FFFFD);
    cfg_commit_pulse();
    chk("basic.cfg_ready_low", 0, 32'(cfg_ready), 32'd0);
    do_swap("basic");
    chk("basic.e0_load", 0, 32'(e0_init_t1), 32'd100);

    // Line stepping, lines 0..2
    do_line("line0", 0);
    chk("line0.e0", 0, 32'(e0_init_t1), 32'd97);
    do_line("line1", 1);
    chk("line1.e0", 0, 32'(e0_init_t1), 32'd94);
    do_line("line2", 2);
    chk("line2.e0", 0, 32'(e0_init_t1), 32'd91);

    // Shared-adder order: bases 0, deltas 1
    for (int a = 0; a < 20; a++) begin
      if ((a >= 6 && a < 12) || (a >= 16)) cfg_write(5'(a), 22'd1);
      else cfg_write(5'(a), 22'd0);
    end
    cfg_commit_pulse();
    do_swap("order");
    tick(10'd640, 10'd0);
    for (int i = 0; i < 10; i++) vec[i] = (dut_acc(i) == 22'd1);
    chk("order.trigger", 0, {22'd0, vec}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick(10'(641 + k), 10'd0);
      for (int i = 0; i < 10; i++) vec[i] = (dut_acc(i) == 22'd1);
      want = 10'((1 << (k + 1)) - 1);
      chk("order.cycle", k, {22'd0, vec}, {22'd0, want});
    end
    tick(10'd799, 10'd0);
    m_steps = 1;
    check_all("order.end");

    // Wrap-around without saturation
    cfg_write(5'd12, 22'h1FFFFF);
    cfg_write(5'd16, 22'd1);
    cfg_write(5'd0, 22'h7FFFF);
    cfg_write(5'd6, 22'd1);
    cfg_commit_pulse();
    do_swap("wrap");
    do_line("wrap.l0", 0);
    chk("wrap.bar_iy", 0, 32'(bar_iy), 32'h200000);
    chk("wrap.e0", 0, 32'(e0_init_t1), 32'h80000);

    // Random frames, including ignored addresses and write+commit in one cycle
    for (int f = 0; f < 2; f++) begin
      for (int a = 0; a < 32; a++) cfg_write(5'(a), 22'($urandom));
      ra = 5'($urandom_range(0, 27));
      write_and_commit(ra, 22'($urandom));
      do_swap("rand");
      for (int l = 0; l < 4; l++) do_line("rand.line", l);
      do_line("rand.l478", 478);
      do_line("rand.l479", 479);
    end

    // Overrun and bank isolation
    cfg_write(5'd0, 22'd1234);
    cfg_commit_pulse();
    cfg_write(5'd0, 22'd55);
    chk("ovr.cfg_ready", 0, 32'(cfg_ready), 32'd0);
    chk_ovr("ovr");
    do_swap("ovr");
    chk("ovr.e0_kept", 0, 32'(e0_init_t1), 32'd1234);
    do_line("ovr.l0", 0);

    // No commit: the previous frame repeats
    do_swap("repeat");
    do_line("repeat.l0", 0);

    // Asynchronous reset in the middle of a step sequence
    tick(10'd640, 10'd1);
    tick(10'd641, 10'd1);
    tick(10'd642, 10'd1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 28; i++) begin m_shadow[i] = 22'd0; m_active[i] = 22'd0; end
    m_pending = 1'b0; m_steps = 0; m_drops = 0;
    check_all("areset");
    chk("areset.frame_swap", 0, 32'(frame_swap), 32'd0);
    chk("areset.cfg_ready", 0, 32'(cfg_ready), 32'd1);
    chk_ovr("areset");
    #2;
    rst_n = 1'b1;
    tick(10'd0, 10'd500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
